// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared state encoding and derived-size helpers for the conv engine
//
// Purpose: holds the engine FSM state type and the functions that derive
// output dimensions, accumulator width and weight-address width from the
// engine parameters, so every file computes them the same way.
// Ports: none (package).
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } conv_state_e;

  // Width of a counter that has to hold 0..n-1; never narrower than 1 bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Number of valid kernel positions along one image axis.
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction

  // Wide enough for K*K products of an unsigned pixel and a signed weight.
  function automatic int acc_w(input int dw, input int k);
    return 2 * dw + $clog2(k * k) + 1;
  endfunction

  // Tap index width (ky*K+kx).
  function automatic int wa_w(input int k);
    return clog2_min1(k * k);
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// rtl/conv_mac_sat.sv - signed multiply-accumulate with clear and mode-selected saturation
//
// Purpose: accumulates pixel*weight products and presents the accumulator
// clamped to DATA_W bits, either unsigned (ReLU) or two's complement.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        load zero into the accumulator (product dropped)
//   en_i         add the current product
//   pix_i        unsigned pixel
//   wgt_i        signed weight
//   relu_i       1: clamp to [0, 2^DATA_W-1]; 0: clamp to signed DATA_W range
//   sat_o        saturated accumulator value
module conv_mac_sat #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 21
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic [DATA_W-1:0]        pix_i,
  input  logic signed [DATA_W-1:0] wgt_i,
  input  logic                     relu_i,
  output logic [DATA_W-1:0]        sat_o
);

  localparam logic signed [ACC_W-1:0] UMAX = {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [2*DATA_W:0] prod;

  // Pixel is zero-extended so it stays non-negative in the signed product.
  assign prod = $signed({1'b0, pix_i}) * wgt_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + ACC_W'(prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  always_comb begin
    sat_o = acc_q[DATA_W-1:0];
    if (relu_i) begin
      if (acc_q[ACC_W-1]) begin
        sat_o = '0;
      end else if (acc_q > UMAX) begin
        sat_o = '1;
      end
    end else begin
      if (acc_q > SMAX) begin
        sat_o = {1'b0, {(DATA_W-1){1'b1}}};
      end else if (acc_q < SMIN) begin
        sat_o = {1'b1, {(DATA_W-1){1'b0}}};
      end
    end
  end

endmodule

// File: rtl/conv_engine_p.sv
// rtl/conv_engine_p.sv - parametrised KxK 2D convolution engine between IFMD and OFMD RAMs
//
// Purpose: on conv_start, walks every output position, reads the KxK window
// from IFMD, accumulates against a runtime-loaded signed weight file and
// writes the saturated result to OFMD, then pulses conv_done.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   conv_start, relu_en          run request and saturation mode (sampled in IDLE)
//   wgt_we, wgt_addr, wgt_in     weight file write port (IDLE only)
//   IFMD_read, read_addr         IFMD read request; IFMD_out returns a cycle later
//   IFMD_out                     pixel data from IFMD
//   OFMD_write, OFMD_addr, OFMD_in  result write port
//   busy, conv_done              run status and completion pulse
module conv_engine_p
  import conv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int K       = 3,
  parameter int STRIDE  = 1,
  parameter int ADDR_W  = 6,
  parameter int OADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     conv_start,
  input  logic                     relu_en,
  input  logic                     wgt_we,
  input  logic [wa_w(K)-1:0]       wgt_addr,
  input  logic signed [DATA_W-1:0] wgt_in,
  output logic                     IFMD_read,
  output logic [ADDR_W-1:0]        read_addr,
  input  logic [DATA_W-1:0]        IFMD_out,
  output logic                     OFMD_write,
  output logic [OADDR_W-1:0]       OFMD_addr,
  output logic [DATA_W-1:0]        OFMD_in,
  output logic                     busy,
  output logic                     conv_done
);

  localparam int OUT_W = out_dim(IMG_W, K, STRIDE);
  localparam int OUT_H = out_dim(IMG_H, K, STRIDE);
  localparam int ACC_W = acc_w(DATA_W, K);
  localparam int TW    = wa_w(K);
  localparam int NTAP  = K * K;
  localparam int XW    = clog2_min1(OUT_W);
  localparam int YW    = clog2_min1(OUT_H);
  localparam int KW    = clog2_min1(K);

  conv_state_e state_q, state_d;
  logic [XW-1:0] ox_q, ox_d;
  logic [YW-1:0] oy_q, oy_d;
  logic [KW-1:0] kx_q, kx_d, ky_q, ky_d;
  logic [TW-1:0] tap_q, tap_d;
  // Tap whose pixel is arriving this cycle; selects the weight for the MAC.
  logic [TW-1:0] ptap_q, ptap_d;
  logic          relu_q, relu_d;
  logic          mac_clr, mac_en;
  logic [DATA_W-1:0] sat;
  logic signed [DATA_W-1:0] wgt_q [NTAP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAP; i++) begin
        wgt_q[i] <= '0;
      end
    end else if (state_q == ST_IDLE && wgt_we && (32'(wgt_addr) < NTAP)) begin
      wgt_q[wgt_addr] <= wgt_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ox_q    <= '0;
      oy_q    <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      tap_q   <= '0;
      ptap_q  <= '0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ox_q    <= ox_d;
      oy_q    <= oy_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      tap_q   <= tap_d;
      ptap_q  <= ptap_d;
      relu_q  <= relu_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ox_d       = ox_q;
    oy_d       = oy_q;
    kx_d       = kx_q;
    ky_d       = ky_q;
    tap_d      = tap_q;
    ptap_d     = ptap_q;
    relu_d     = relu_q;
    IFMD_read  = 1'b0;
    OFMD_write = 1'b0;
    conv_done  = 1'b0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (conv_start) begin
          relu_d  = relu_en;
          ox_d    = '0;
          oy_d    = '0;
          kx_d    = '0;
          ky_d    = '0;
          tap_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        IFMD_read = 1'b1;
        // The first tap has no pixel in flight yet, so it only clears.
        if (tap_q == '0) begin
          mac_clr = 1'b1;
        end else begin
          mac_en = 1'b1;
        end
        ptap_d = tap_q;
        tap_d  = tap_q + 1'b1;
        if (kx_q == KW'(K - 1)) begin
          kx_d = '0;
          ky_d = ky_q + 1'b1;
        end else begin
          kx_d = kx_q + 1'b1;
        end
        if (tap_q == TW'(NTAP - 1)) begin
          tap_d   = '0;
          kx_d    = '0;
          ky_d    = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        mac_en  = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        OFMD_write = 1'b1;
        state_d    = ST_READ;
        if (ox_q == XW'(OUT_W - 1)) begin
          ox_d = '0;
          if (oy_q == YW'(OUT_H - 1)) begin
            oy_d    = '0;
            state_d = ST_DONE;
          end else begin
            oy_d = oy_q + 1'b1;
          end
        end else begin
          ox_d = ox_q + 1'b1;
        end
      end
      ST_DONE: begin
        conv_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  conv_mac_sat #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .pix_i (IFMD_out),
    .wgt_i (wgt_q[ptap_q]),
    .relu_i(relu_q),
    .sat_o (sat)
  );

  assign busy = (state_q == ST_READ) || (state_q == ST_DRAIN) || (state_q == ST_WRITE);

  assign read_addr = (state_q == ST_READ) ?
      (ADDR_W'(oy_q) * ADDR_W'(STRIDE) + ADDR_W'(ky_q)) * ADDR_W'(IMG_W)
      + ADDR_W'(ox_q) * ADDR_W'(STRIDE) + ADDR_W'(kx_q) : '0;

  assign OFMD_addr = (state_q == ST_WRITE) ?
      OADDR_W'(oy_q) * OADDR_W'(OUT_W) + OADDR_W'(ox_q) : '0;

  assign OFMD_in = (state_q == ST_WRITE) ? sat : '0;

endmodule

// File: tb/tb_conv_engine_p.sv
// tb/tb_conv_engine_p.sv - self-checking bench for conv_engine_p (stride 1 and stride 2 instances)
module tb_conv_engine_p;

  logic       clk;
  logic       rst_n;
  logic       conv_start, s2_start, relu_en, wgt_we;
  logic [3:0] wgt_addr;
  logic [7:0] wgt_in;

  logic       IFMD_read, OFMD_write, busy, conv_done;
  logic [5:0] read_addr, OFMD_addr;
  logic [7:0] IFMD_out, OFMD_in;
  logic       s2_IFMD_read, s2_OFMD_write, s2_busy, s2_conv_done;
  logic [5:0] s2_read_addr, s2_OFMD_addr;
  logic [7:0] s2_IFMD_out, s2_OFMD_in;

  logic [7:0] mem [64];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic       mon_clr;
  logic [7:0] ofmd [36];
  int         ofmd_cnt [36];
  int         wr_total, done_cnt, rd_idx, busy_rise, done_cyc;
  logic [5:0] rd_log [32];
  logic       busy_prev;
  logic [7:0] s2_ofmd [9];
  int         s2_wr_total, s2_done_cnt, s2_rd_idx, s2_busy_rise, s2_done_cyc;
  logic [5:0] s2_rd_log [16];
  logic       s2_busy_prev;

  conv_engine_p u_dut (
    .clk(clk), .rst_n(rst_n), .conv_start(conv_start), .relu_en(relu_en),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_in(wgt_in),
    .IFMD_read(IFMD_read), .read_addr(read_addr), .IFMD_out(IFMD_out),
    .OFMD_write(OFMD_write), .OFMD_addr(OFMD_addr), .OFMD_in(OFMD_in),
    .busy(busy), .conv_done(conv_done)
  );

  conv_engine_p #(.STRIDE(2)) u_dut_s2 (
    .clk(clk), .rst_n(rst_n), .conv_start(s2_start), .relu_en(relu_en),
    .wgt_we(wgt_we), .wgt_addr(wgt_addr), .wgt_in(wgt_in),
    .IFMD_read(s2_IFMD_read), .read_addr(s2_read_addr), .IFMD_out(s2_IFMD_out),
    .OFMD_write(s2_OFMD_write), .OFMD_addr(s2_OFMD_addr), .OFMD_in(s2_OFMD_in),
    .busy(s2_busy), .conv_done(s2_conv_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // IFMD RAM models: one-cycle read latency.
  always @(posedge clk) begin
    if (IFMD_read) IFMD_out <= mem[read_addr];
    if (s2_IFMD_read) s2_IFMD_out <= mem[s2_read_addr];
  end

  always @(negedge clk) begin
    if (mon_clr) begin
      wr_total <= 0; done_cnt <= 0; rd_idx <= 0; busy_prev <= 1'b0;
      s2_wr_total <= 0; s2_done_cnt <= 0; s2_rd_idx <= 0; s2_busy_prev <= 1'b0;
      for (int i = 0; i < 36; i++) ofmd_cnt[i] <= 0;
    end else begin
      if (OFMD_write) begin
        if (OFMD_addr < 36) begin
          ofmd[OFMD_addr] <= OFMD_in;
          ofmd_cnt[OFMD_addr] <= ofmd_cnt[OFMD_addr] + 1;
        end
        wr_total <= wr_total + 1;
      end
      if (IFMD_read && rd_idx < 32) begin
        rd_log[rd_idx[4:0]] <= read_addr;
        rd_idx <= rd_idx + 1;
      end
      if (busy && !busy_prev) busy_rise <= cyc;
      if (conv_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      busy_prev <= busy;
      if (s2_OFMD_write) begin
        if (s2_OFMD_addr < 9) s2_ofmd[s2_OFMD_addr] <= s2_OFMD_in;
        s2_wr_total <= s2_wr_total + 1;
      end
      if (s2_IFMD_read && s2_rd_idx < 16) begin
        s2_rd_log[s2_rd_idx[3:0]] <= s2_read_addr;
        s2_rd_idx <= s2_rd_idx + 1;
      end
      if (s2_busy && !s2_busy_prev) s2_busy_rise <= cyc;
      if (s2_conv_done) begin
        s2_done_cnt <= s2_done_cnt + 1;
        s2_done_cyc <= cyc;
      end
      s2_busy_prev <= s2_busy;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill_mem(input bit ident, input logic [7:0] v);
    for (int i = 0; i < 64; i++) mem[i] = ident ? 8'(i) : v;
  endtask

  task automatic load_wgt(input logic [7:0] w, input bit center_only);
    for (int t = 0; t < 9; t++) begin
      wgt_we = 1'b1;
      wgt_addr = 4'(t);
      wgt_in = center_only ? ((t == 4) ? 8'd1 : 8'd0) : w;
      tick(1);
    end
    wgt_we = 1'b0;
  endtask

  task automatic start_run(input bit sel, input logic relu);
    mon_clr = 1'b1;
    tick(1);
    mon_clr = 1'b0;
    relu_en = relu;
    if (sel) s2_start = 1'b1; else conv_start = 1'b1;
    tick(1);
    conv_start = 1'b0;
    s2_start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string tag);
    for (int i = 0; i < 2000 && (sel ? s2_done_cnt : done_cnt) == 0; i++) tick(1);
    tick(5);
    if (sel) begin
      check({tag, "_done_cnt"}, s2_done_cnt, 1);
      check({tag, "_writes"}, s2_wr_total, 9);
      check({tag, "_latency"}, s2_done_cyc - s2_busy_rise, 99);
    end else begin
      check({tag, "_done_cnt"}, done_cnt, 1);
      check({tag, "_writes"}, wr_total, 36);
      check({tag, "_latency"}, done_cyc - busy_rise, 396);
    end
  endtask

  task automatic check_const(input logic [7:0] e, input string tag);
    for (int a = 0; a < 36; a++) begin
      check($sformatf("%s_out%0d", tag, a), int'(ofmd[a]), int'(e));
      check($sformatf("%s_wcnt%0d", tag, a), ofmd_cnt[a], 1);
    end
  endtask

  typedef struct {
    logic [7:0] pix;
    logic [7:0] wgt;
    logic       relu;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [10];
  int   exp_rd [9];

  initial begin
    vecs[0] = '{8'd1,   8'd1,   1'b0, 8'd9};    // 9
    vecs[1] = '{8'd255, 8'd127, 1'b0, 8'h7F};   // 291465 -> 127
    vecs[2] = '{8'd255, 8'hFF,  1'b1, 8'h00};   // -2295 -> 0
    vecs[3] = '{8'd255, 8'hFF,  1'b0, 8'h80};   // -2295 -> -128
    vecs[4] = '{8'd1,   8'hFF,  1'b0, 8'hF7};   // -9
    vecs[5] = '{8'd10,  8'd2,   1'b1, 8'hB4};   // 180 fits unsigned
    vecs[6] = '{8'd10,  8'd2,   1'b0, 8'h7F};   // 180 -> 127
    vecs[7] = '{8'd15,  8'd2,   1'b1, 8'hFF};   // 270 -> 255
    vecs[8] = '{8'd7,   8'd2,   1'b0, 8'd126};  // 126 just inside
    vecs[9] = '{8'd3,   8'hFD,  1'b0, 8'hAF};   // -81
    exp_rd = '{0, 1, 2, 8, 9, 10, 16, 17, 18};

    rst_n = 1'b1; conv_start = 1'b0; s2_start = 1'b0; relu_en = 1'b0;
    wgt_we = 1'b0; wgt_addr = '0; wgt_in = '0; mon_clr = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(conv_done), 0);
    check("rst_ifmd_read", int'(IFMD_read), 0);
    check("rst_ofmd_write", int'(OFMD_write), 0);
    check("rst_read_addr", int'(read_addr), 0);
    check("rst_ofmd_in", int'(OFMD_in), 0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Table-driven saturation / arithmetic vectors.
    for (int v = 0; v < 10; v++) begin
      fill_mem(1'b0, vecs[v].pix);
      load_wgt(vecs[v].wgt, 1'b0);
      start_run(1'b0, vecs[v].relu);
      wait_done(1'b0, $sformatf("vec%0d", v));
      check_const(vecs[v].exp, $sformatf("vec%0d", v));
    end

    // Identity kernel with out-of-range weight writes that must be dropped.
    fill_mem(1'b1, 8'd0);
    load_wgt(8'd0, 1'b1);
    wgt_we = 1'b1; wgt_in = 8'd77;
    wgt_addr = 4'd9;  tick(1);
    wgt_addr = 4'd12; tick(1);
    wgt_addr = 4'd15; tick(1);
    wgt_we = 1'b0;
    start_run(1'b0, 1'b0);
    wait_done(1'b0, "ident");
    for (int i = 0; i < 9; i++) check($sformatf("ident_rd%0d", i), int'(rd_log[i]), exp_rd[i]);
    for (int oy = 0; oy < 6; oy++)
      for (int ox = 0; ox < 6; ox++)
        check($sformatf("ident_out%0d", oy * 6 + ox), int'(ofmd[oy * 6 + ox]), (oy + 1) * 8 + ox + 1);

    // Stride 2 instance, same identity kernel.
    start_run(1'b1, 1'b0);
    wait_done(1'b1, "s2");
    check("s2_rd_out0_first", int'(s2_rd_log[0]), 0);
    check("s2_rd_out1_first", int'(s2_rd_log[9]), 2);
    for (int oy = 0; oy < 3; oy++)
      for (int ox = 0; ox < 3; ox++)
        check($sformatf("s2_out%0d", oy * 3 + ox), int'(s2_ofmd[oy * 3 + ox]),
              (oy * 2 + 1) * 8 + ox * 2 + 1);

    // Weight write and start request while busy must be ignored.
    fill_mem(1'b0, 8'd1);
    load_wgt(8'd1, 1'b0);
    start_run(1'b0, 1'b0);
    tick(40);
    check("mid_busy", int'(busy), 1);
    wgt_we = 1'b1; wgt_addr = 4'd4; wgt_in = 8'd50; conv_start = 1'b1;
    tick(1);
    wgt_we = 1'b0; conv_start = 1'b0;
    wait_done(1'b0, "mid");
    tick(20);
    check("mid_done_after", done_cnt, 1);
    check_const(8'd9, "mid");

    // Reset after the fifth write aborts the run and clears the weights.
    start_run(1'b0, 1'b0);
    for (int i = 0; i < 200 && wr_total < 5; i++) tick(1);
    check("abort_writes_before", wr_total, 5);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_ifmd_read", int'(IFMD_read), 0);
    check("abort_ofmd_write", int'(OFMD_write), 0);
    check("abort_read_addr", int'(read_addr), 0);
    check("abort_ofmd_addr", int'(OFMD_addr), 0);
    check("abort_ofmd_in", int'(OFMD_in), 0);
    tick(3);
    rst_n = 1'b1;
    tick(30);
    check("abort_writes_after", wr_total, 5);
    check("abort_no_done", done_cnt, 0);
    start_run(1'b0, 1'b0);
    wait_done(1'b0, "zero_wgt");
    check_const(8'd0, "zero_wgt");
    load_wgt(8'd1, 1'b0);
    start_run(1'b0, 1'b0);
    wait_done(1'b0, "reload");
    check_const(8'd9, "reload");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_engine_p.md
Name: conv_engine_p

Overview:
Parametrised successor to the fixed 8x8/3x3 conv block. It performs a KxK 2D convolution over an IMG_W x IMG_H image held in IFMD_ram and writes results to the OFMD memory. It adds a runtime-loadable signed weight file, configurable stride, a ReLU mode, output saturation, a busy flag and async reset. It sits between the fsm (conv_start/conv_done handshake) and the IFMD/OFMD RAMs.

Parameters:
DATA_W, 8, pixel/weight/output width
IMG_W, 8, image width in pixels
IMG_H, 8, image height in pixels
K, 3, kernel edge (KxK taps), 1 <= K <= min(IMG_W, IMG_H)
STRIDE, 1, horizontal and vertical step
ADDR_W, 6, IFMD address width, >= clog2(IMG_W*IMG_H)
OADDR_W, 6, OFMD address width, >= clog2(OUT_W*OUT_H)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
conv_start  in  1  start request, level or pulse; sampled only in IDLE
relu_en  in  1  ReLU/unsigned-saturation mode; latched at start
wgt_we  in  1  weight write strobe, honoured only in IDLE
wgt_addr  in  WA_W=clog2(K*K)  tap index, ky*K+kx
wgt_in  in  DATA_W  signed weight
IFMD_read  out  1  read enable to IFMD_ram
read_addr  out  ADDR_W  IFMD read address
IFMD_out  in  DATA_W  unsigned pixel, valid 1 cycle after IFMD_read
OFMD_write  out  1  output write strobe, 1 cycle per result
OFMD_addr  out  OADDR_W  output address
OFMD_in  out  DATA_W  output data
busy  out  1  high while convolving
conv_done  out  1  single-cycle completion pulse

Behaviour:
- Derived values: OUT_W=(IMG_W-K)/STRIDE+1, OUT_H=(IMG_H-K)/STRIDE+1, ACC_W=2*DATA_W+clog2(K*K)+1.
- Products are pixel (zero-extended) times weight (signed); the accumulator is signed ACC_W wide and never overflows.
- Reset (rst_n low, async): state IDLE, all outputs 0, all counters 0, all weights 0.
- States:
  - IDLE: a write with wgt_we=1 stores wgt_in at wgt_addr, ignored if wgt_addr >= K*K. conv_start=1 latches relu_en, clears ox/oy and goes to READ. busy goes high the following cycle.
  - READ: K*K cycles. IFMD_read=1 and read_addr=(oy*STRIDE+ky)*IMG_W+ox*STRIDE+kx, with kx fastest. In each cycle the accumulator adds the product of the previous tap, whose data has arrived. The accumulator clears on the first tap.
  - DRAIN: 1 cycle. IFMD_read=0 and the last product is added.
  - WRITE: 1 cycle. OFMD_write=1, OFMD_addr=oy*OUT_W+ox, OFMD_in=sat(acc). ox advances first, then oy. After the last output go to DONE, otherwise go to READ.
  - DONE: 1 cycle. conv_done=1, busy=0, then IDLE.
- Saturation:
  - relu_en=1: clamp to [0, 2^DATA_W-1].
  - relu_en=0: clamp to signed [-2^(DATA_W-1), 2^(DATA_W-1)-1], two's complement.
- Latency: exactly OUT_W*OUT_H*(K*K+2) busy cycles. conv_done comes in the cycle after the last WRITE.
- conv_start held high or re-asserted while busy is ignored. If conv_start is still high in IDLE after DONE, a new run starts.
- wgt_we while busy is ignored, so weights are stable for a whole run.
- IFMD_read, OFMD_write and conv_done are 0 in every state not listed for them.
- rst_n asserted mid-run aborts immediately with no conv_done and no further writes. Weights return to 0.

Decomposition:
- Shared package conv_pkg holds the state encoding (IDLE, READ, DRAIN, WRITE, DONE) and the function-style constants for OUT_W, OUT_H, ACC_W and WA_W.
- One natural sub-module, conv_mac_sat: a signed MAC with clear, plus the mode-selected saturation. The address/counter FSM and the weight register file stay in conv_engine_p.

Test Plan:
- Default params, all pixels 1, all weights 1, relu_en=0 -> 36 writes at addresses 0..35, each OFMD_in=9. conv_done comes 396 cycles after busy rises.
- Pixel p[i]=i, weights center=1 and all others 0 -> OFMD[oy*6+ox]=p[(oy+1)*8+ox+1]. Check that the read_addr sequence for output 0 is 0,1,2,8,9,10,16,17,18.
- Pixels 255, weights 127, relu_en=0 -> every output 127 (saturated). Then weights -1 with relu_en=1 -> every output 0. Then weights -1 with relu_en=0 -> every output -128 (0x80).
- STRIDE=2 -> OUT_W=OUT_H=3, 9 writes; output 1 reads start at addr 2; 9*11 busy cycles.
- wgt_we and conv_start pulsed mid-run -> weights unchanged, no restart, exactly one conv_done.
- rst_n low after the 5th write -> outputs 0 at once, no conv_done. A fresh run after weight reload completes normally.
